// File: rtl/digitizer_pulse_counter_if.sv
// Frame-control and result bus of the digitizer pulse counter.
// The DUT sits on the slave side; the frame source and result consumer sit on the master side.
interface digitizer_pulse_counter_if #(
  parameter int CNT_W = 32
);
  logic             gate;
  logic             pulse_in;
  logic [CNT_W-1:0] expected_n;
  logic             clr_err;
  logic [CNT_W-1:0] res_count;
  logic [CNT_W-1:0] res_len;
  logic             res_mismatch;
  logic             res_timeout;
  logic             res_valid;
  logic             res_ready;
  logic             overrun_err;
  logic             sat_err;

  modport master (
    output gate, pulse_in, expected_n, clr_err, res_ready,
    input  res_count, res_len, res_mismatch, res_timeout, res_valid,
           overrun_err, sat_err
  );

  modport slave (
    input  gate, pulse_in, expected_n, clr_err, res_ready,
    output res_count, res_len, res_mismatch, res_timeout, res_valid,
           overrun_err, sat_err
  );
endinterface

// File: rtl/digitizer_pulse_counter.sv
// Counts gated pulses per gate-delimited frame, closes frames on gate or timeout,
// and reports each frame through a one-deep valid/ready result register.
module digitizer_pulse_counter #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 32
) (
  input logic                    clk,
  input logic                    rst,
  digitizer_pulse_counter_if.slave bus
);
  typedef enum logic {IDLE, ACQ} state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [63:0]      TO_LEN   = 64'(TIMEOUT_CYCLES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, len, exp_q;
  logic [CNT_W-1:0] cnt_nxt, len_nxt, exp_nxt;
  logic [CNT_W-1:0] cnt_inc, len_inc;
  logic             cnt_sat, timeout_hit;

  logic             close;
  logic [CNT_W-1:0] close_cnt, close_len;
  logic             close_to;
  logic             sat_set;

  logic [CNT_W-1:0] res_count, res_len;
  logic             res_mismatch, res_timeout, res_valid;
  logic             overrun_err, sat_err;
  logic             xfer, ovr_set;

  // Saturating increments; the timeout compare is widened so len+1 never wraps.
  always_comb begin
    cnt_sat     = bus.pulse_in && (cnt == ALL_ONES);
    cnt_inc     = cnt_sat ? cnt : cnt + CNT_W'(bus.pulse_in);
    len_inc     = (len == ALL_ONES) ? len : len + CNT_W'(1);
    timeout_hit = (64'(len) + 64'd1) == TO_LEN;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.gate) state_nxt = ACQ;
      ACQ:  if (!bus.gate && timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    close     = 1'b0;
    close_cnt = cnt;
    close_len = len;
    close_to  = 1'b0;
    sat_set   = 1'b0;
    cnt_nxt   = cnt;
    len_nxt   = len;
    exp_nxt   = exp_q;
    case (state)
      IDLE: begin
        if (bus.gate) begin
          cnt_nxt = CNT_W'(bus.pulse_in);
          len_nxt = CNT_W'(1);
          exp_nxt = bus.expected_n;
        end
      end
      ACQ: begin
        if (bus.gate) begin
          // A pulse coincident with gate belongs to the frame being opened.
          close   = 1'b1;
          cnt_nxt = CNT_W'(bus.pulse_in);
          len_nxt = CNT_W'(1);
          exp_nxt = bus.expected_n;
        end else begin
          sat_set = cnt_sat;
          if (timeout_hit) begin
            close     = 1'b1;
            close_cnt = cnt_inc;
            close_len = TO_LEN[CNT_W-1:0];
            close_to  = 1'b1;
            cnt_nxt   = '0;
            len_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
            len_nxt = len_inc;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      len   <= '0;
      exp_q <= '0;
    end else begin
      cnt   <= cnt_nxt;
      len   <= len_nxt;
      exp_q <= exp_nxt;
    end
  end

  assign xfer    = res_valid && bus.res_ready;
  assign ovr_set = close && res_valid && !bus.res_ready;

  // A close only lands when the slot is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid    <= 1'b0;
      res_count    <= '0;
      res_len      <= '0;
      res_mismatch <= 1'b0;
      res_timeout  <= 1'b0;
    end else if (close && (!res_valid || xfer)) begin
      res_valid    <= 1'b1;
      res_count    <= close_cnt;
      res_len      <= close_len;
      res_mismatch <= (close_cnt != exp_q);
      res_timeout  <= close_to;
    end else if (xfer) begin
      res_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_err <= 1'b0;
      sat_err     <= 1'b0;
    end else begin
      if (ovr_set)          overrun_err <= 1'b1;
      else if (bus.clr_err) overrun_err <= 1'b0;
      if (sat_set)          sat_err     <= 1'b1;
      else if (bus.clr_err) sat_err     <= 1'b0;
    end
  end

  assign bus.res_valid    = res_valid;
  assign bus.res_count    = res_count;
  assign bus.res_len      = res_len;
  assign bus.res_mismatch = res_mismatch;
  assign bus.res_timeout  = res_timeout;
  assign bus.overrun_err  = overrun_err;
  assign bus.sat_err      = sat_err;
endmodule

// File: tb/tb_digitizer_pulse_counter.sv
// Directed and randomized checks of digitizer_pulse_counter against a frame-level reference model.
module tb_digitizer_pulse_counter;
  localparam int CW   = 8;
  localparam int TO   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  digitizer_pulse_counter_if #(.CNT_W(CW)) bus ();
  digitizer_pulse_counter_if #(.CNT_W(4))  sbus ();

  digitizer_pulse_counter #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  // Narrow counter with an unreachable timeout, so saturation can be exercised.
  digitizer_pulse_counter #(.TIMEOUT_CYCLES(1000), .CNT_W(4)) sdut (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame bookkeeping in plain integers.
  bit          m_open;
  int          m_cnt, m_len, m_exp;
  bit          m_valid, m_mis, m_to, m_ovr, m_sat;
  logic [CW-1:0] m_count, m_rlen;

  function automatic void model_step(bit g, bit p, int n, bit rdy, bit clr, bit r);
    bit xfer, cl, sset, oset, c_to;
    int c, c_cnt, c_len;
    if (r) begin
      m_open = 0; m_cnt = 0; m_len = 0; m_exp = 0;
      m_valid = 0; m_count = '0; m_rlen = '0; m_mis = 0; m_to = 0;
      m_ovr = 0; m_sat = 0;
      return;
    end
    xfer = m_valid && rdy;
    cl = 0; sset = 0; oset = 0; c_to = 0; c_cnt = 0; c_len = 0;
    if (m_open && !g) begin
      c = m_cnt + int'(p);
      if (c > MAXC) begin c = MAXC; sset = 1; end
      if (m_len + 1 == TO) begin
        cl = 1; c_cnt = c; c_len = TO; c_to = 1; m_open = 0;
      end else begin
        m_cnt = c;
        m_len = (m_len + 1 > MAXC) ? MAXC : m_len + 1;
      end
    end else if (g && m_open) begin
      cl = 1; c_cnt = m_cnt; c_len = m_len; c_to = 0;
    end
    if (cl) begin
      if (!m_valid || xfer) begin
        m_valid = 1; m_count = CW'(c_cnt); m_rlen = CW'(c_len);
        m_mis = (c_cnt != m_exp); m_to = c_to;
      end else oset = 1;
    end else if (xfer) m_valid = 0;
    if (g) begin
      m_open = 1; m_cnt = int'(p); m_len = 1; m_exp = n;
    end
    m_ovr = oset ? 1'b1 : (clr ? 1'b0 : m_ovr);
    m_sat = sset ? 1'b1 : (clr ? 1'b0 : m_sat);
  endfunction

  task automatic tick(input bit g, input bit p, input int n, input bit rdy, input bit clr, input bit r);
    bus.gate = g; bus.pulse_in = p; bus.expected_n = CW'(n);
    bus.res_ready = rdy; bus.clr_err = clr; rst = r;
    @(posedge clk);
    model_step(g, p, n, rdy, clr, r);
    #1;
  endtask

  task automatic stick(input bit g, input bit p, input bit clr);
    sbus.gate = g; sbus.pulse_in = p; sbus.clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(0, 0, 0, 1, 0, 1);
    tick(1, 1, 3, 1, 0, 1);
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.res_valid); end
    n_checks++; if (bus.res_count !== '0 || bus.res_len !== '0) begin n_fail++; $display("FAIL reset_fields got %0d/%0d want 0/0", bus.res_count, bus.res_len); end
    n_checks++; if (bus.overrun_err !== 1'b0 || bus.sat_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", bus.overrun_err, bus.sat_err); end
    n_checks++; if (sbus.res_valid !== 1'b0 || sbus.sat_err !== 1'b0) begin n_fail++; $display("FAIL reset_sdut got %b%b want 00", sbus.res_valid, sbus.sat_err); end
  endtask

  task automatic test_basic;
    for (int c = 0; c <= 10; c++) tick(c == 0 || c == 10, c <= 3, 4, 1, 0, 0);
    n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.res_valid); end
    n_checks++; if (bus.res_count !== 8'd4 || bus.res_len !== 8'd10) begin n_fail++; $display("FAIL basic_fields got %0d/%0d want 4/10", bus.res_count, bus.res_len); end
    n_checks++; if (bus.res_mismatch !== 1'b0 || bus.res_timeout !== 1'b0) begin n_fail++; $display("FAIL basic_flags got %b%b want 00", bus.res_mismatch, bus.res_timeout); end
  endtask

  task automatic test_coincident;
    tick(0, 0, 0, 1, 0, 1);
    for (int c = 0; c <= 10; c++) tick(c == 0 || c == 10, c <= 3 || c == 10, 4, 1, 0, 0);
    n_checks++; if (bus.res_count !== 8'd4) begin n_fail++; $display("FAIL coincident_first got %0d want 4", bus.res_count); end
    tick(0, 0, 4, 1, 0, 0);
    tick(1, 0, 4, 1, 0, 0);
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_count !== 8'd1 || bus.res_len !== 8'd2) begin
      n_fail++; $display("FAIL coincident_second got v%b %0d/%0d want v1 1/2", bus.res_valid, bus.res_count, bus.res_len); end
  endtask

  task automatic test_timeout;
    tick(0, 0, 0, 1, 0, 1);
    for (int c = 0; c < TO; c++) tick(c == 0, c <= 2, 5, 1, 0, 0);
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_count !== 8'd3 || bus.res_len !== 8'd16) begin
      n_fail++; $display("FAIL timeout_fields got v%b %0d/%0d want v1 3/16", bus.res_valid, bus.res_count, bus.res_len); end
    n_checks++; if (bus.res_timeout !== 1'b1 || bus.res_mismatch !== 1'b1) begin n_fail++; $display("FAIL timeout_flags got %b%b want 11", bus.res_timeout, bus.res_mismatch); end
    for (int c = 0; c < 4; c++) tick(0, 1, 5, 1, 0, 0);
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_idle got %b want 0", bus.res_valid); end
    tick(1, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    n_checks++; if (bus.res_count !== 8'd0 || bus.res_len !== 8'd1) begin n_fail++; $display("FAIL timeout_ignored got %0d/%0d want 0/1", bus.res_count, bus.res_len); end
  endtask

  task automatic test_overrun;
    tick(0, 0, 0, 1, 0, 1);
    for (int c = 0; c <= 10; c++) tick(c % 5 == 0, 0, 2, 0, 0, 0);
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_len !== 8'd5) begin n_fail++; $display("FAIL overrun_held got v%b len %0d want v1 5", bus.res_valid, bus.res_len); end
    n_checks++; if (bus.overrun_err !== 1'b1) begin n_fail++; $display("FAIL overrun_set got %b want 1", bus.overrun_err); end
    tick(0, 0, 2, 0, 1, 0);
    n_checks++; if (bus.overrun_err !== 1'b0) begin n_fail++; $display("FAIL overrun_clr got %b want 0", bus.overrun_err); end
    tick(1, 0, 2, 0, 1, 0);
    n_checks++; if (bus.overrun_err !== 1'b1) begin n_fail++; $display("FAIL overrun_set_wins got %b want 1", bus.overrun_err); end
    tick(0, 0, 2, 1, 1, 0);
    n_checks++; if (bus.res_valid !== 1'b0 || bus.overrun_err !== 1'b0) begin n_fail++; $display("FAIL overrun_drain got %b%b want 00", bus.res_valid, bus.overrun_err); end
  endtask

  task automatic test_mismatch;
    tick(0, 0, 0, 1, 0, 1);
    tick(1, 1, 4, 1, 0, 0);
    tick(0, 1, 9, 1, 0, 0);
    tick(0, 1, 9, 1, 0, 0);
    tick(0, 0, 3, 1, 0, 0);
    tick(1, 0, 9, 1, 0, 0);
    n_checks++; if (bus.res_count !== 8'd3 || bus.res_mismatch !== 1'b1) begin n_fail++; $display("FAIL mismatch_short got %0d m%b want 3 m1", bus.res_count, bus.res_mismatch); end
    for (int c = 0; c < 9; c++) tick(0, 1, 2, 1, 0, 0);
    tick(1, 0, 2, 1, 0, 0);
    n_checks++; if (bus.res_count !== 8'd9 || bus.res_mismatch !== 1'b0) begin n_fail++; $display("FAIL mismatch_exact got %0d m%b want 9 m0", bus.res_count, bus.res_mismatch); end
  endtask

  task automatic test_reset_mid;
    tick(1, 1, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0);
    n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending got %b want 1", bus.res_valid); end
    tick(0, 1, 1, 0, 0, 1);
    n_checks++; if (bus.res_valid !== 1'b0 || bus.res_count !== '0) begin n_fail++; $display("FAIL rstmid_discard got v%b %0d want v0 0", bus.res_valid, bus.res_count); end
    tick(1, 1, 1, 1, 0, 0);
    tick(1, 0, 1, 1, 0, 0);
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_count !== 8'd1 || bus.res_len !== 8'd1) begin
      n_fail++; $display("FAIL rstmid_reopen got v%b %0d/%0d want v1 1/1", bus.res_valid, bus.res_count, bus.res_len); end
  endtask

  task automatic test_random;
    bit g, p, rdy, clr, r;
    int n, gate_div;
    for (int c = 0; c < 4000; c++) begin
      gate_div = (c / 500) % 2 == 0 ? 6 : 20;
      g   = ($urandom % gate_div) == 0;
      p   = $urandom % 2;
      rdy = ($urandom % 4) != 0;
      clr = ($urandom % 40) == 0;
      r   = ($urandom % 300) == 0;
      n   = $urandom_range(0, 6);
      tick(g, p, n, rdy, clr, r);
      n_checks++;
      if (bus.res_valid !== m_valid || bus.overrun_err !== m_ovr || bus.sat_err !== m_sat) begin
        n_fail++; $display("FAIL rand_ctrl cyc %0d got v%b o%b s%b want v%b o%b s%b", c,
          bus.res_valid, bus.overrun_err, bus.sat_err, m_valid, m_ovr, m_sat); end
      if (m_valid) begin
        n_checks++;
        if (bus.res_count !== m_count || bus.res_len !== m_rlen || bus.res_mismatch !== m_mis || bus.res_timeout !== m_to) begin
          n_fail++; $display("FAIL rand_result cyc %0d got %0d/%0d m%b t%b want %0d/%0d m%b t%b", c,
            bus.res_count, bus.res_len, bus.res_mismatch, bus.res_timeout, m_count, m_rlen, m_mis, m_to); end
      end
    end
  endtask

  task automatic test_saturation;
    bus.gate = 0; bus.pulse_in = 0; bus.res_ready = 1; bus.clr_err = 0; rst = 0;
    sbus.expected_n = '0; sbus.res_ready = 1;
    stick(1, 1, 0);
    for (int c = 0; c < 19; c++) stick(0, 1, 0);
    n_checks++; if (sbus.sat_err !== 1'b1) begin n_fail++; $display("FAIL sat_set got %b want 1", sbus.sat_err); end
    stick(1, 0, 0);
    n_checks++; if (sbus.res_count !== 4'd15 || sbus.res_len !== 4'd15) begin n_fail++; $display("FAIL sat_fields got %0d/%0d want 15/15", sbus.res_count, sbus.res_len); end
    stick(0, 1, 1);
    n_checks++; if (sbus.sat_err !== 1'b0) begin n_fail++; $display("FAIL sat_clr got %b want 0", sbus.sat_err); end
    for (int c = 0; c < 14; c++) stick(0, 1, 0);
    n_checks++; if (sbus.sat_err !== 1'b0) begin n_fail++; $display("FAIL sat_early got %b want 0", sbus.sat_err); end
    stick(0, 1, 1);
    n_checks++; if (sbus.sat_err !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins got %b want 1", sbus.sat_err); end
  endtask

  initial begin
    bus.gate = 0; bus.pulse_in = 0; bus.expected_n = '0; bus.clr_err = 0; bus.res_ready = 1;
    sbus.gate = 0; sbus.pulse_in = 0; sbus.expected_n = '0; sbus.clr_err = 0; sbus.res_ready = 1;
    test_reset;
    test_basic;
    test_coincident;
    test_timeout;
    test_overrun;
    test_mismatch;
    test_reset_mid;
    test_random;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
